// File: rtl/timer_ctrl.sv
// timer_ctrl: period timer with one-shot or periodic mode, pause/hold,
// a one-cycle terminal-count pulse (tc) and a sticky interrupt (irq).
// States: IDLE, RUN, HOLD, DONE. All outputs are registered.
// Optional feature macro: TIMER_CTRL_PRESCALE_EN adds a prescale input that
// divides the advance rate by prescale+1. Without the macro the counter
// advances on every RUN cycle.
module timer_ctrl #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          mode,
  input  logic [N-1:0]  period,
`ifdef TIMER_CTRL_PRESCALE_EN
  input  logic [PW-1:0] prescale,
`endif
  input  logic          irq_ack,
  output logic [N-1:0]  count,
  output logic          busy,
  output logic          paused,
  output logic          tc,
  output logic          irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_r;
  logic [N-1:0]  period_r;
  logic          mode_r;
  logic [PW-1:0] psc_cnt_r;
  logic [PW-1:0] psc_lim_s;
  logic          start_ok_s;
  logic          advance_s;
  logic          tc_hit_s;
  logic          tc_set_s;

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PW-1:0] prescale_r;

  // Capture the prescale divisor together with period and mode on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_r <= {PW{1'b0}};
    end else if (!stop && start_ok_s) begin
      prescale_r <= prescale;
    end else begin
      prescale_r <= prescale_r;
    end
  end

  assign psc_lim_s = prescale_r;
`else
  // Without the prescaler the limit is zero, so every RUN cycle is an advance.
  assign psc_lim_s = {PW{1'b0}};
`endif

  // Decode start qualification, advance and terminal-count conditions.
  always_comb begin
    start_ok_s = start && (period != {N{1'b0}});
    advance_s  = (state_r == RUN) && !pause && (psc_cnt_r == psc_lim_s);
    tc_hit_s   = advance_s && (count >= period_r);
    if (stop || start_ok_s) begin
      // A coincident stop or start pre-empts the terminal count.
      tc_set_s = 1'b0;
    end else begin
      tc_set_s = tc_hit_s;
    end
  end

  // Main timer state machine with registered count, status and tc outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      count     <= {N{1'b0}};
      period_r  <= {N{1'b0}};
      mode_r    <= 1'b0;
      psc_cnt_r <= {PW{1'b0}};
      busy      <= 1'b0;
      paused    <= 1'b0;
      tc        <= 1'b0;
    end else begin
      tc <= tc_set_s;
      if (stop) begin
        state_r   <= IDLE;
        count     <= {N{1'b0}};
        psc_cnt_r <= {PW{1'b0}};
        busy      <= 1'b0;
        paused    <= 1'b0;
      end else if (start_ok_s) begin
        state_r   <= RUN;
        period_r  <= period;
        mode_r    <= mode;
        count     <= {N{1'b0}};
        psc_cnt_r <= {PW{1'b0}};
        busy      <= 1'b1;
        paused    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            busy   <= 1'b0;
            paused <= 1'b0;
          end
          RUN: begin
            if (pause) begin
              // Freeze count and prescaler until pause drops.
              state_r <= HOLD;
              busy    <= 1'b1;
              paused  <= 1'b1;
            end else if (advance_s) begin
              psc_cnt_r <= {PW{1'b0}};
              if (!tc_hit_s) begin
                count <= count + N'(1);
              end else if (mode_r) begin
                count <= {N{1'b0}};
              end else begin
                // One-shot: park at the terminal value.
                state_r <= DONE;
                busy    <= 1'b0;
              end
            end else begin
              psc_cnt_r <= psc_cnt_r + PW'(1);
            end
          end
          HOLD: begin
            if (!pause) begin
              // Resume; counting restarts on the following edge.
              state_r <= RUN;
              paused  <= 1'b0;
            end else begin
              paused  <= 1'b1;
            end
          end
          DONE: begin
            busy   <= 1'b0;
            paused <= 1'b0;
          end
          default: begin
            state_r   <= IDLE;
            count     <= {N{1'b0}};
            psc_cnt_r <= {PW{1'b0}};
            busy      <= 1'b0;
            paused    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky interrupt: terminal count sets it, acknowledge clears it, set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else if (tc_set_s) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end else begin
      irq <= irq;
    end
  end

endmodule
